// File: rtl/alpu_slice_sequencer.sv
// Issues one wide operation to a REG_WIDTH ALPU slice by slice, LSB first,
// and returns the assembled wide result over a valid/ready port.
module alpu_slice_sequencer #(
   parameter  int REG_WIDTH  = 4,
   parameter  int NUM_SLICES = 4,
   localparam int OP_WIDTH   = REG_WIDTH * NUM_SLICES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [OP_WIDTH-1:0]  req_a_i,
   input  logic [OP_WIDTH-1:0]  req_b_i,
   input  logic [3:0]           req_instr_i,
   input  logic                 req_cin_i,
   input  logic                 req_chain_i,
   output logic [REG_WIDTH-1:0] alpu_a_o,
   output logic [REG_WIDTH-1:0] alpu_b_o,
   output logic [3:0]           alpu_instr_o,
   output logic                 alpu_cin_o,
   input  logic [REG_WIDTH-1:0] alpu_out_i,
   input  logic                 alpu_cout_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [OP_WIDTH-1:0]  rsp_out_o,
   output logic                 rsp_cout_o,
   output logic                 busy_o
);

   localparam int CW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]                         r_cnt;
   logic [NUM_SLICES-1:0][REG_WIDTH-1:0]  r_a;
   logic [NUM_SLICES-1:0][REG_WIDTH-1:0]  r_b;
   logic [NUM_SLICES-1:0][REG_WIDTH-1:0]  r_res;
   logic [3:0]                            r_instr;
   logic                                  r_cin;
   logic                                  r_chain;
   logic                                  r_carry;
   logic                                  r_cout;

   logic w_accept;
   logic w_exec;
   logic w_last;

   assign w_accept = req_valid_i & (r_state == S_IDLE);
   assign w_exec   = (r_state == S_EXEC);
   assign w_last   = (r_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      req_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      busy_o       = 1'b1;
      alpu_a_o     = '0;
      alpu_b_o     = '0;
      alpu_instr_o = '0;
      alpu_cin_o   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (req_valid_i) w_next = S_EXEC;
         end
         S_EXEC: begin
            alpu_a_o     = r_a[r_cnt];
            alpu_b_o     = r_b[r_cnt];
            alpu_instr_o = r_instr;
            alpu_cin_o   = r_carry;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
            busy_o = 1'b0;
         end
      endcase
   end

   // Carry reg feeds the next slice; r_cout keeps the final slice's cout only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_instr <= '0;
         r_cin   <= 1'b0;
         r_chain <= 1'b0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= req_a_i;
         r_b     <= req_b_i;
         r_instr <= req_instr_i;
         r_cin   <= req_cin_i;
         r_chain <= req_chain_i;
         r_carry <= req_cin_i;
         r_cnt   <= '0;
      end else if (w_exec) begin
         r_res[r_cnt] <= alpu_out_i;
         r_carry      <= r_chain ? alpu_cout_i : r_cin;
         r_cout       <= alpu_cout_i;
         r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign rsp_out_o  = r_res;
   assign rsp_cout_o = r_cout;

endmodule

// File: tb/tb_alpu_slice_sequencer.sv
// Randomised bench for alpu_slice_sequencer with a small combinational ALPU
// model and a whole-word reference model of the wide operation.
module tb_alpu_slice_sequencer;

   localparam int RW = 4;
   localparam int NS = 4;
   localparam int OW = RW * NS;

   logic          clk;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [OW-1:0] req_a;
   logic [OW-1:0] req_b;
   logic [3:0]    req_instr;
   logic          req_cin;
   logic          req_chain;
   logic [RW-1:0] alpu_a;
   logic [RW-1:0] alpu_b;
   logic [3:0]    alpu_instr;
   logic          alpu_cin;
   logic [RW-1:0] alpu_out;
   logic          alpu_cout;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [OW-1:0] rsp_out;
   logic          rsp_cout;
   logic          busy;

   int tests;
   int fails;

   logic [NS-1:0][RW-1:0] cap_a;
   logic [NS-1:0]         cap_cin;

   alpu_slice_sequencer #(
      .REG_WIDTH  (RW),
      .NUM_SLICES (NS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_instr_i  (req_instr),
      .req_cin_i    (req_cin),
      .req_chain_i  (req_chain),
      .alpu_a_o     (alpu_a),
      .alpu_b_o     (alpu_b),
      .alpu_instr_o (alpu_instr),
      .alpu_cin_o   (alpu_cin),
      .alpu_out_i   (alpu_out),
      .alpu_cout_i  (alpu_cout),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_out_o    (rsp_out),
      .rsp_cout_o   (rsp_cout),
      .busy_o       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALPU model: 0 add, 1 and, 2 or, 3 xor (upper instr bits ignored)
   logic [RW:0] w_sum;
   assign w_sum = {1'b0, alpu_a} + {1'b0, alpu_b} + {{RW{1'b0}}, alpu_cin};

   always_comb begin
      alpu_out  = '0;
      alpu_cout = 1'b0;
      case (alpu_instr[1:0])
         2'd0: begin
            alpu_out  = w_sum[RW-1:0];
            alpu_cout = w_sum[RW];
         end
         2'd1: alpu_out = alpu_a & alpu_b;
         2'd2: alpu_out = alpu_a | alpu_b;
         default: alpu_out = alpu_a ^ alpu_b;
      endcase
   end

   function automatic logic [OW:0] ref_op(
      input logic [OW-1:0] a,
      input logic [OW-1:0] b,
      input logic [3:0]    ins,
      input logic          cin,
      input logic          chain
   );
      logic [OW-1:0] r;
      logic          c;
      int            s;
      r = '0;
      c = 1'b0;
      case (ins[1:0])
         2'd0: begin
            if (chain) begin
               return {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
            end
            for (int k = 0; k < NS; k++) begin
               s = int'(a[k*RW +: RW]) + int'(b[k*RW +: RW]) + int'(cin);
               r[k*RW +: RW] = RW'(s);
               c = s >= (1 << RW);
            end
            return {c, r};
         end
         2'd1: return {1'b0, a & b};
         2'd2: return {1'b0, a | b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   task automatic do_op(
      input  logic [OW-1:0] a,
      input  logic [OW-1:0] b,
      input  logic [3:0]    ins,
      input  logic          cin,
      input  logic          chain,
      input  int            hold,
      output logic [OW-1:0] res,
      output logic          rc,
      output int            lat
   );
      int  n;
      bit  found;
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_instr = ins;
      req_cin   = cin;
      req_chain = chain;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a     = OW'($urandom);
      req_b     = OW'($urandom);
      req_instr = 4'($urandom);
      req_cin   = 1'($urandom);
      req_chain = 1'($urandom);
      cap_a     = '0;
      cap_cin   = '0;
      lat       = 0;
      n         = 0;
      found     = 1'b0;
      for (int i = 0; i < NS + 8 && !found; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            found = 1'b1;
         end else begin
            if (n < NS) begin
               cap_a[n]   = alpu_a;
               cap_cin[n] = alpu_cin;
            end
            n++;
            @(posedge clk);
            lat++;
         end
      end
      if (!found) lat = -1;
      res = rsp_out;
      rc  = rsp_cout;
      if (hold >= 0) begin
         repeat (hold) @(negedge clk);
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_instr = '0;
      req_cin   = 1'b0;
      req_chain = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         fails++;
         $display("FAIL reset_ctrl: ready/valid/busy=%b want 100",
                  {req_ready, rsp_valid, busy});
      end
      tests++;
      if ({rsp_out, rsp_cout} !== '0) begin
         fails++;
         $display("FAIL reset_rsp: out=%h cout=%b want 0", rsp_out, rsp_cout);
      end
      tests++;
      if ({alpu_a, alpu_b, alpu_instr, alpu_cin} !== '0) begin
         fails++;
         $display("FAIL reset_alpu: a=%h b=%h i=%h c=%b want 0",
                  alpu_a, alpu_b, alpu_instr, alpu_cin);
      end
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         fails++;
         $display("FAIL post_reset: ready/valid/busy=%b want 100",
                  {req_ready, rsp_valid, busy});
      end
   endtask

   task automatic test_chained_add;
      logic [OW-1:0] r;
      logic          c;
      int            lat;
      do_op(16'h0FFF, 16'h0001, 4'h0, 1'b0, 1'b1, 0, r, c, lat);
      tests++;
      if (cap_cin !== 4'b1110) begin
         fails++;
         $display("FAIL chain_cin_seq: got %b want 1110", cap_cin);
      end
      tests++;
      if (r !== 16'h1000 || c !== 1'b0) begin
         fails++;
         $display("FAIL chain_add: got %h/%b want 1000/0", r, c);
      end
      tests++;
      if (lat !== NS) begin
         fails++;
         $display("FAIL chain_latency: got %0d want %0d", lat, NS);
      end
   endtask

   task automatic test_overflow;
      logic [OW-1:0] r;
      logic          c;
      int            lat;
      do_op(16'hFFFF, 16'h0001, 4'h0, 1'b0, 1'b1, 1, r, c, lat);
      tests++;
      if (r !== 16'h0000 || c !== 1'b1) begin
         fails++;
         $display("FAIL overflow: got %h/%b want 0000/1", r, c);
      end
   endtask

   task automatic test_unchained;
      logic [OW-1:0] r;
      logic          c;
      int            lat;
      do_op(16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0, 0, r, c, lat);
      tests++;
      if (cap_cin !== 4'b1111) begin
         fails++;
         $display("FAIL unchain_cin_seq: got %b want 1111", cap_cin);
      end
      tests++;
      if (r !== 16'h1111 || c !== 1'b0) begin
         fails++;
         $display("FAIL unchain: got %h/%b want 1111/0", r, c);
      end
   endtask

   task automatic test_backpressure;
      logic [OW-1:0] r;
      logic          c;
      int            lat;
      int            bad;
      do_op(16'h4321, 16'h0000, 4'h0, 1'b0, 1'b1, -1, r, c, lat);
      tests++;
      if (cap_a !== 16'h4321) begin
         fails++;
         $display("FAIL slice_order: got %h want 4321", cap_a);
      end
      tests++;
      if (r !== 16'h4321) begin
         fails++;
         $display("FAIL order_result: got %h want 4321", r);
      end
      bad = 0;
      req_valid = 1'b1;
      req_a     = 16'hAAAA;
      req_b     = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_out !== 16'h4321 || req_ready || !busy)
            bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL hold_stable: %0d bad cycles want 0", bad);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      tests++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         fails++;
         $display("FAIL bp_release: ready/valid/busy=%b want 100",
                  {req_ready, rsp_valid, busy});
      end
      do_op(16'h0102, 16'h0304, 4'h0, 1'b0, 1'b1, 0, r, c, lat);
      tests++;
      if (r !== 16'h0406 || lat !== NS) begin
         fails++;
         $display("FAIL after_bp: got %h lat %0d want 0406 lat %0d",
                  r, lat, NS);
      end
   endtask

   task automatic test_reset_mid;
      logic [OW-1:0] r;
      logic          c;
      int            lat;
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 16'h1234;
      req_b     = 16'h1111;
      req_instr = 4'h0;
      req_cin   = 1'b0;
      req_chain = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (alpu_a !== 4'h3) begin
         fails++;
         $display("FAIL mid_second_slice: a=%h want 3", alpu_a);
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if ({alpu_a, alpu_b, alpu_instr, alpu_cin} !== '0) begin
         fails++;
         $display("FAIL mid_reset_alpu: a=%h b=%h i=%h c=%b want 0",
                  alpu_a, alpu_b, alpu_instr, alpu_cin);
      end
      tests++;
      if ({req_ready, rsp_valid, busy} !== 3'b100) begin
         fails++;
         $display("FAIL mid_reset_ctrl: ready/valid/busy=%b want 100",
                  {req_ready, rsp_valid, busy});
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_no_rsp: valid=%b busy=%b want 0/0",
                  rsp_valid, busy);
      end
      do_op(16'h0001, 16'h0001, 4'h0, 1'b0, 1'b1, 0, r, c, lat);
      tests++;
      if (r !== 16'h0002 || c !== 1'b0) begin
         fails++;
         $display("FAIL after_reset_op: got %h/%b want 0002/0", r, c);
      end
   endtask

   task automatic test_random;
      logic [OW-1:0] a;
      logic [OW-1:0] b;
      logic [3:0]    ins;
      logic          cin;
      logic          ch;
      logic [OW-1:0] r;
      logic          c;
      logic [OW:0]   exp;
      int            lat;
      for (int i = 0; i < 40; i++) begin
         a   = OW'($urandom);
         b   = OW'($urandom);
         ins = 4'($urandom);
         cin = 1'($urandom);
         ch  = 1'($urandom);
         exp = ref_op(a, b, ins, cin, ch);
         do_op(a, b, ins, cin, ch, int'($urandom_range(0, 3)), r, c, lat);
         tests++;
         if ({c, r} !== exp) begin
            fails++;
            $display("FAIL rand_result[%0d]: got %b/%h want %b/%h",
                     i, c, r, exp[OW], exp[OW-1:0]);
         end
         tests++;
         if (cap_a !== a) begin
            fails++;
            $display("FAIL rand_slices[%0d]: got %h want %h", i, cap_a, a);
         end
         tests++;
         if (lat !== NS) begin
            fails++;
            $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, NS);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_chained_add();
      test_overflow();
      test_unchained();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alpu_slice_sequencer.md
Name: alpu_slice_sequencer

Overview:
- Driver-side master for a REG_WIDTH-wide ALPU slice.
- Accepts one wide operation (NUM_SLICES*REG_WIDTH bits) over a valid/ready request port.
- Issues it to the ALPU one REG_WIDTH slice per cycle, LSB slice first, optionally chaining carry between slices.
- Assembles the wide result and returns it over a valid/ready response port.
- Sits between the issue logic and a combinational ALPU instance.

Parameters:
- REG_WIDTH, 4, width of one ALPU slice (a/b/out).
- NUM_SLICES, 4, number of slices per wide operation; must be >= 1. Derived OP_WIDTH = REG_WIDTH*NUM_SLICES.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  sequencer can accept a request.
- req_a_i  input  OP_WIDTH  wide operand A.
- req_b_i  input  OP_WIDTH  wide operand B.
- req_instr_i  input  4  ALPU instruction, applied to every slice.
- req_cin_i  input  1  carry-in for slice 0.
- req_chain_i  input  1  1: slice k+1 cin = slice k cout; 0: every slice gets req_cin_i.
- alpu_a_o  output  REG_WIDTH  to ALPU a_i.
- alpu_b_o  output  REG_WIDTH  to ALPU b_i.
- alpu_instr_o  output  4  to ALPU instr_i.
- alpu_cin_o  output  1  to ALPU cin_i.
- alpu_out_i  input  REG_WIDTH  from ALPU out_o.
- alpu_cout_i  input  1  from ALPU cout_o.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- rsp_out_o  output  OP_WIDTH  assembled wide result.
- rsp_cout_o  output  1  cout of the final slice.
- busy_o  output  1  high in EXEC or DONE.

Behaviour:
- ALPU is combinational: alpu_out_i/alpu_cout_i are valid in the same cycle the alpu_* outputs are driven. They are sampled at the clock edge ending that cycle.
- States: IDLE, EXEC, DONE. Reset state IDLE.
- Reset (async, reset_n low): state=IDLE, slice counter=0, operand/result/carry registers=0.
  - Output values during and after reset: req_ready_o=1, rsp_valid_o=0, rsp_out_o=0, rsp_cout_o=0, busy_o=0, all alpu_* outputs=0.
  - Reset asserted mid-EXEC or mid-DONE aborts the operation with no response.
- IDLE:
  - req_ready_o=1; alpu_* outputs=0.
  - On req_valid_i & req_ready_o: latch a, b, instr, cin, chain; carry reg <= req_cin_i; counter <= 0; go to EXEC.
- EXEC:
  - req_ready_o=0.
  - Drive slice k = counter: alpu_a_o=A[k*REG_WIDTH +: REG_WIDTH] (likewise B), alpu_instr_o=latched instr, alpu_cin_o=carry reg.
  - Each edge: result slice k <= alpu_out_i; carry reg <= chain ? alpu_cout_i : latched cin; last-cout reg <= alpu_cout_i; counter++.
  - When counter==NUM_SLICES-1, go to DONE on that edge.
  - Exactly NUM_SLICES EXEC cycles; no stalls.
- DONE:
  - rsp_valid_o=1; rsp_out_o/rsp_cout_o are registered and held stable until handshake.
  - alpu_* outputs=0; req_ready_o=0.
  - On rsp_ready_i: go to IDLE, rsp_valid_o drops next cycle.
- Latency: request accepted at edge T → first slice driven in cycle T+1 → rsp_valid_o high from edge T+NUM_SLICES onward.
  - Minimum request-to-request spacing is NUM_SLICES+2 cycles.
- No request is accepted in EXEC or DONE; req_valid_i there is ignored and not queued.
- rsp_ready_i in IDLE/EXEC is ignored.
- Request payload changes after acceptance have no effect.
- NUM_SLICES=1: single EXEC cycle, then DONE.
- Carry chain does not wrap: the final slice cout goes only to rsp_cout_o, never back to slice 0.

Test Plan:
(REG_WIDTH=4, NUM_SLICES=4; bench ALPU model where instr 4'h0 = a+b+cin.)
- Chained add: a=16'h0FFF, b=16'h0001, cin=0, chain=1, instr=0
  → alpu_cin_o per EXEC cycle 0,1,1,1; rsp_out_o=16'h1000, rsp_cout_o=0; rsp_valid_o first high 4 edges after acceptance.
- Overflow: a=16'hFFFF, b=16'h0001, chain=1
  → rsp_out_o=16'h0000, rsp_cout_o=1.
- Unchained: a=16'h0000, b=16'h0000, cin=1, chain=0
  → alpu_cin_o=1 every slice; rsp_out_o=16'h1111, rsp_cout_o=0.
- Slice order and backpressure: a=16'h4321, b=0, cin=0, chain=1
  → alpu_a_o sequence 1,2,3,4; rsp_out_o=16'h4321.
  - Hold rsp_ready_i=0 for 10 cycles: rsp_valid_o/rsp_out_o stable, req_ready_o=0, a concurrent req_valid_i is ignored.
  - Raise rsp_ready_i: IDLE next cycle, next request accepted the cycle after.
- Reset mid-operation: assert reset_n=0 during the 2nd EXEC cycle
  → immediately alpu_* =0, rsp_valid_o=0, busy_o=0, req_ready_o=1.
  - After release, a fresh a=16'h0001, b=16'h0001 request returns 16'h0002.
